// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the ALU datapath blocks.
//   addsub_op_t     operation select for the add/subtract unit (OP_ADD / OP_SUB)
//   addsub_flags_t  result flags carried alongside an add/sub result {co, ovf, zero}
//   full_adder()    one-bit full adder cell, returns {carry_out, sum}
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

  typedef struct packed {
    logic co;
    logic ovf;
    logic zero;
  } addsub_flags_t;

  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational SLICE-bit ripple adder built from full_adder cells.
//   a, b  in   SLICE  operand slices (b already inverted by the caller for subtract)
//   ci    in   1      carry into bit 0 of the slice
//   s     out  SLICE  sum slice
//   co    out  1      carry out of the slice MSB
//   mci   out  1      carry into the slice MSB (co ^ mci is signed overflow when
//                     this slice holds the word's sign bit)
module addsub_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             mci
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < SLICE; i++) begin
      {c[i+1], s[i]} = full_adder(a[i], b[i], c[i]);
    end
  end

  assign co  = c[SLICE];
  assign mci = c[SLICE-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep pipelined add/subtract unit with valid/ready
// handshake on both sides. Each stage resolves the carry chain of one
// WIDTH/STAGES-bit slice; unresolved operand slices travel with the beat.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      beat accepted this cycle when in_valid & in_ready
//   a, b       in   WIDTH  operands
//   ci         in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: o = a + b + ci   1: o = a - b - ci
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   o          out  WIDTH  result, mod 2^WIDTH
//   co         out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed two's-complement overflow
//   zero       out  1      o == 0
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SLICE = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  addsub_op_t       op;
  logic [WIDTH-1:0] b_enc;
  logic             ci_enc;
  logic             advance;
  addsub_flags_t    flags_q;

  // a - b - ci == a + ~b + ~ci, so subtract reuses the adder unchanged.
  assign op     = addsub_op_t'(sub);
  assign b_enc  = (op == OP_SUB) ? ~b : b;
  assign ci_enc = (op == OP_SUB) ? ~ci : ci;

  // Whole pipe moves together; it only freezes when a result is waiting.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign co   = flags_q.co;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * SLICE;   // result bits already resolved upstream
    localparam int unsigned REM = WIDTH - LO;  // operand bits still pending, incl. this slice

    logic [REM-1:0]      a_in;
    logic [REM-1:0]      b_in;
    logic                c_in;
    logic                v_in;
    logic [SLICE-1:0]    s_slice;
    logic                c_slice;
    logic [LO+SLICE-1:0] s_next;
    logic [LO+SLICE-1:0] s_q;
    logic                v_q;

    // Operands are kept right-aligned: each stage consumes the low slice and
    // forwards the rest, so the final stage sees only the sign-bit slice.
    if (k == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b_enc;
      assign c_in   = ci_enc;
      assign v_in   = in_valid;
      assign s_next = s_slice;
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].g_fwd.c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {s_slice, g_stage[k-1].s_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        s_q <= s_next;
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic msb_ci;

      addsub_slice #(.SLICE(SLICE)) u_slice (
        .a   (a_in[SLICE-1:0]),
        .b   (b_in[SLICE-1:0]),
        .ci  (c_in),
        .s   (s_slice),
        .co  (c_slice),
        .mci (msb_ci)
      );

      // Carry into the sign bit differs from carry out exactly when the
      // operand signs agree and the result sign flips.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_q <= '0;
        end else if (advance) begin
          flags_q <= '{co: c_slice, ovf: c_slice ^ msb_ci, zero: ~|s_next};
        end
      end

      assign o         = s_q;
      assign out_valid = v_q;
    end else begin : g_fwd
      logic                 msb_ci_unused;
      logic [REM-SLICE-1:0] a_q;
      logic [REM-SLICE-1:0] b_q;
      logic                 c_q;

      addsub_slice #(.SLICE(SLICE)) u_slice (
        .a   (a_in[SLICE-1:0]),
        .b   (b_in[SLICE-1:0]),
        .ci  (c_in),
        .s   (s_slice),
        .co  (c_slice),
        .mci (msb_ci_unused)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (advance) begin
          a_q <= a_in[REM-1:SLICE];
          b_q <= b_in[REM-1:SLICE];
          c_q <= c_slice;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int unsigned W   = 32;
  localparam int unsigned S   = 4;
  localparam int unsigned NSW = 4;

  typedef struct {
    logic [W-1:0] o;
    logic         co;
    logic         ovf;
    logic         zero;
    int unsigned  t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] o;
  logic         co;
  logic         ovf;
  logic         zero;

  logic         sw_ir  [NSW];
  logic         sw_ov  [NSW];
  logic [W-1:0] sw_o   [NSW];
  logic         sw_co  [NSW];
  logic         sw_ovf [NSW];
  logic         sw_z   [NSW];

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  bit          lat_chk = 1'b1;
  exp_t        sb[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .co        (co),
    .ovf       (ovf),
    .zero      (zero)
  );

  function automatic int unsigned sw_stages(input int unsigned i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    localparam int unsigned SS = sw_stages(i);
    pipelined_addsub #(.WIDTH(W), .STAGES(SS)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (sw_ir[i]),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (sw_ov[i]),
      .out_ready (out_ready),
      .o         (sw_o[i]),
      .co        (sw_co[i]),
      .ovf       (sw_ovf[i]),
      .zero      (sw_z[i])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] ro, input logic rco, input logic rovf,
                              input logic rzero);
    exp_t e;
    e.o = ro; e.co = rco; e.ovf = rovf; e.zero = rzero; e.t = 0;
    return e;
  endfunction

  // Golden model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t        e;
    logic [W:0]  wide;
    logic [W:0]  yc;
    longint      exact;
    yc = {1'b0, y} + {{W{1'b0}}, c};
    if (!s) begin
      wide  = {1'b0, x} + yc;
      exact = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      e.co  = wide[W];
    end else begin
      wide  = {1'b0, x} - yc;
      exact = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
      e.co  = ({1'b0, x} >= yc);
    end
    e.o    = wide[W-1:0];
    e.ovf  = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    e.zero = (e.o == '0);
    e.t    = 0;
    return e;
  endfunction

  // One clock cycle on the main DUT: drive, check outputs against the
  // scoreboard front, record accepted beat, advance to the next negedge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic c, input logic s, input logic ordy,
                             input logic exp_ir, input exp_t e);
    exp_t f;
    exp_t n;
    in_valid = v; a = x; b = y; ci = c; sub = s; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, exp_ir);
    if (lat_chk)
      chk("out_valid_timing", out_valid, (sb.size() != 0) && (sb[0].t + S == cyc));
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        f = sb[0];
        chk("o", o, f.o);
        chk("flags_co_ovf_zero", {co, ovf, zero}, {f.co, f.ovf, f.zero});
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (v && in_ready) begin
      n   = e;
      n.t = cyc;
      sb.push_back(n);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, mk('0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      idle_cycle();
      n++;
    end
    chk("drain_all_results_seen", sb.size(), 0);
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         v;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    logic         s;
    int unsigned  n;
    int unsigned  guard;
    int unsigned  lat [NSW];
    logic [W-1:0] corner [4];
    exp_t         ew;

    corner[0] = '0;
    corner[1] = '1;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_o", o, '0);
    chk("rst_flags", {co, ovf, zero}, 3'b000);
    for (int unsigned i = 0; i < NSW; i++) begin
      chk($sformatf("rst_sw%0d_out_valid", i), sw_ov[i], 1'b0);
      chk($sformatf("rst_sw%0d_in_ready", i), sw_ir[i], 1'b1);
    end
    rst_n = 1'b1;

    // Directed cases with fixed expected values
    drive_cycle(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1,
                mk(32'h0, 1'b1, 1'b0, 1'b1));
    drive_cycle(1'b1, 32'h5, 32'h7, 1'b0, 1'b1, 1'b1, 1'b1,
                mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    drive_cycle(1'b1, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1,
                mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    drain(20);

    // Random stream, out_ready held high, occasional bubbles
    n = 0;
    guard = 0;
    while (n < 100 && guard < 1000) begin
      v = ($urandom_range(0, 7) != 0);
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 4) == 0) x = corner[$urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0) y = corner[$urandom_range(0, 3)];
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (v) n++;
      drive_cycle(v, x, y, c, s, 1'b1, 1'b1, model(x, y, c, s));
      guard++;
    end
    drain(20);

    // Backpressure: full pipe, out_ready low for 6 cycles
    lat_chk = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, x, y, c, s, 1'b1, 1'b1, model(x, y, c, s));
    end
    x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
    for (int unsigned i = 0; i < 6; i++)
      drive_cycle(1'b1, x, y, c, s, 1'b0, 1'b0, model(x, y, c, s));
    drive_cycle(1'b1, x, y, c, s, 1'b1, 1'b1, model(x, y, c, s));
    for (int unsigned i = 0; i < 10; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, x, y, c, s, 1'b1, 1'b1, model(x, y, c, s));
    end
    drain(40);
    lat_chk = 1'b1;

    // Reset with three beats in flight
    for (int unsigned i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, x, y, c, s, 1'b1, 1'b1, model(x, y, c, s));
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_o", o, '0);
    chk("midrst_flags", {co, ovf, zero}, 3'b000);
    sb.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1, 1'b1,
                mk(32'h2222_2222, 1'b0, 1'b0, 1'b0));
    drain(20);

    // Depth sweep: latency and full-width carry/borrow ripple
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned bt = 0; bt < 2; bt++) begin
      if (bt == 0) begin
        x = 32'h7FFF_FFFF; y = 32'h1; c = 1'b0; s = 1'b0;
        ew = mk(32'h8000_0000, 1'b0, 1'b1, 1'b0);
      end else begin
        x = '0; y = '0; c = 1'b1; s = 1'b1;
        ew = mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      end
      in_valid = 1'b1; a = x; b = y; ci = c; sub = s; out_ready = 1'b1;
      #1;
      for (int unsigned i = 0; i < NSW; i++)
        chk($sformatf("sweep%0d_in_ready", i), sw_ir[i], 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int unsigned i = 0; i < NSW; i++) lat[i] = 0;
      for (int unsigned k = 1; k <= 40; k++) begin
        for (int unsigned i = 0; i < NSW; i++) begin
          if (sw_ov[i] && lat[i] == 0) begin
            lat[i] = k;
            chk($sformatf("sweep%0d_o", i), sw_o[i], ew.o);
            chk($sformatf("sweep%0d_flags", i), {sw_co[i], sw_ovf[i], sw_z[i]},
                {ew.co, ew.ovf, ew.zero});
          end
        end
        @(posedge clk);
        @(negedge clk);
      end
      for (int unsigned i = 0; i < NSW; i++)
        chk($sformatf("sweep%0d_latency", i), lat[i], sw_stages(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
